// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multicycle controller.
//   - state_t : FSM state codes (FETCH=0 ... IMM_WB=11), also exported on state_o
//   - OP_*    : supported primary opcodes (instruction bits 31:26)
//   - ALUOP_*, SRCB_*, PCSRC_* : datapath select encodings
//   - ctrl_t  : bundle of every control output produced per state
package mc_pkg;

    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_MEM_ADR = 4'd2,
        ST_MEM_RD  = 4'd3,
        ST_MEM_WB  = 4'd4,
        ST_MEM_WR  = 4'd5,
        ST_EXEC_R  = 4'd6,
        ST_R_WB    = 4'd7,
        ST_BRANCH  = 4'd8,
        ST_JUMP    = 4'd9,
        ST_IMM_EX  = 4'd10,
        ST_IMM_WB  = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OPDEC = 2'b11;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_wr;
        logic       pc_wr_cond;
        logic       iord;
        logic       mem_rd;
        logic       mem_wr;
        logic       ir_wr;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_wr;
        logic       alu_src_a;
        logic       ext_op;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [1:0] alu_op;
        logic       retire;
    } ctrl_t;

endpackage

// File: rtl/mc_out_dec.sv
// mc_out_dec: purely combinational control-output decoder.
//   state_i   : current FSM state
//   mem_rdy_i : effective memory-ready (gates IRWr/PCWr in FETCH and retire in MEM_WR)
//   op_i      : opcode, only consulted in IMM_EX to pick sign/zero extension
//   ctrl_o    : full control bundle; anything not set for a state stays 0
module mc_out_dec
    import mc_pkg::*;
(
    input  state_t     state_i,
    input  logic       mem_rdy_i,
    input  logic [5:0] op_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            ST_FETCH: begin
                ctrl_o.mem_rd    = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.pc_src    = PCSRC_ALU;
                // IR load and PC+4 only on the cycle the read actually lands
                ctrl_o.ir_wr     = mem_rdy_i;
                ctrl_o.pc_wr     = mem_rdy_i;
            end
            ST_DECODE: begin
                // speculative branch target: PC + (imm << 2)
                ctrl_o.alu_src_b = SRCB_IMM_SH2;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.ext_op    = 1'b1;
            end
            ST_MEM_ADR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.ext_op    = 1'b1;
            end
            ST_MEM_RD: begin
                ctrl_o.mem_rd = 1'b1;
                ctrl_o.iord   = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl_o.reg_wr     = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.retire     = 1'b1;
            end
            ST_MEM_WR: begin
                ctrl_o.mem_wr = 1'b1;
                ctrl_o.iord   = 1'b1;
                // a store completes only when the write is accepted
                ctrl_o.retire = mem_rdy_i;
            end
            ST_EXEC_R: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_REGB;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            ST_R_WB: begin
                ctrl_o.reg_wr  = 1'b1;
                ctrl_o.reg_dst = 1'b1;
                ctrl_o.retire  = 1'b1;
            end
            ST_BRANCH: begin
                ctrl_o.alu_src_a  = 1'b1;
                ctrl_o.alu_src_b  = SRCB_REGB;
                ctrl_o.alu_op     = ALUOP_SUB;
                ctrl_o.pc_wr_cond = 1'b1;
                ctrl_o.pc_src     = PCSRC_ALUOUT;
                ctrl_o.retire     = 1'b1;
            end
            ST_JUMP: begin
                ctrl_o.pc_wr  = 1'b1;
                ctrl_o.pc_src = PCSRC_JUMP;
                ctrl_o.retire = 1'b1;
            end
            ST_IMM_EX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_OPDEC;
                // addi sign-extends; ori zero-extends
                ctrl_o.ext_op    = (op_i == OP_ADDI);
            end
            ST_IMM_WB: begin
                ctrl_o.reg_wr = 1'b1;
                ctrl_o.retire = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle MIPS-style control FSM (Moore, plus mem_rdy-gated
// IRWr/PCWr in FETCH and retire in MEM_WR).
//   clk, rst      : clock, synchronous active-high reset
//   mem_rdy       : memory access completes this cycle
//   op, funct     : instruction fields (funct passes through to the ALU decoder elsewhere)
//   PCWr..ExtOp   : 1-bit datapath strobes/selects
//   ALUSrcB/PCSrc/ALUOp : 2-bit selects
//   state_o       : current state code
//   retire        : one-cycle instruction-complete pulse
//   ill_op        : sticky flag, set when DECODE sees an unsupported opcode
// While rst is high every output reads 0.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mem_rdy,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic       PCWr,
    output logic       PCWrCond,
    output logic       IorD,
    output logic       MemRd,
    output logic       MemWr,
    output logic       IRWr,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWr,
    output logic       ALUSrcA,
    output logic       ExtOp,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [1:0] ALUOp,
    output logic [3:0] state_o,
    output logic       retire,
    output logic       ill_op
);

    state_t state_q, state_d;
    logic   ill_op_q, ill_op_d;
    logic   rdy_eff;
    ctrl_t  ctrl_raw;
    ctrl_t  ctrl_out;

    // funct is decoded by the ALU control block, not here
    logic unused_funct;
    assign unused_funct = ^funct;

    // With MEM_WAIT=0 memory is assumed single-cycle
    assign rdy_eff = mem_rdy | (MEM_WAIT == 0);

    always_comb begin
        state_d  = state_q;
        ill_op_d = ill_op_q;
        case (state_q)
            ST_FETCH:   if (rdy_eff) state_d = ST_DECODE;
            ST_DECODE: begin
                case (op)
                    OP_LW, OP_SW:     state_d = ST_MEM_ADR;
                    OP_RTYPE:         state_d = ST_EXEC_R;
                    OP_BEQ:           state_d = ST_BRANCH;
                    OP_J:             state_d = ST_JUMP;
                    OP_ADDI, OP_ORI:  state_d = ST_IMM_EX;
                    default: begin
                        state_d  = ST_FETCH;
                        ill_op_d = 1'b1;
                    end
                endcase
            end
            ST_MEM_ADR: state_d = (op == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:  if (rdy_eff) state_d = ST_MEM_WB;
            ST_MEM_WB:  state_d = ST_FETCH;
            ST_MEM_WR:  if (rdy_eff) state_d = ST_FETCH;
            ST_EXEC_R:  state_d = ST_R_WB;
            ST_R_WB:    state_d = ST_FETCH;
            ST_BRANCH:  state_d = ST_FETCH;
            ST_JUMP:    state_d = ST_FETCH;
            ST_IMM_EX:  state_d = ST_IMM_WB;
            ST_IMM_WB:  state_d = ST_FETCH;
            default:    state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_FETCH;
            ill_op_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ill_op_q <= ill_op_d;
        end
    end

    mc_out_dec u_out_dec (
        .state_i   (state_q),
        .mem_rdy_i (rdy_eff),
        .op_i      (op),
        .ctrl_o    (ctrl_raw)
    );

    // Reset blanks the outputs immediately, not just from the next edge
    assign ctrl_out = rst ? '0 : ctrl_raw;

    assign PCWr     = ctrl_out.pc_wr;
    assign PCWrCond = ctrl_out.pc_wr_cond;
    assign IorD     = ctrl_out.iord;
    assign MemRd    = ctrl_out.mem_rd;
    assign MemWr    = ctrl_out.mem_wr;
    assign IRWr     = ctrl_out.ir_wr;
    assign MemtoReg = ctrl_out.mem_to_reg;
    assign RegDst   = ctrl_out.reg_dst;
    assign RegWr    = ctrl_out.reg_wr;
    assign ALUSrcA  = ctrl_out.alu_src_a;
    assign ExtOp    = ctrl_out.ext_op;
    assign ALUSrcB  = ctrl_out.alu_src_b;
    assign PCSrc    = ctrl_out.pc_src;
    assign ALUOp    = ctrl_out.alu_op;
    assign retire   = ctrl_out.retire;
    assign state_o  = rst ? 4'd0 : state_q;
    assign ill_op   = ill_op_q & ~rst;

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 Parameter MEM_WAIT, default 1, meaning: 1 = FETCH/MEM_RD/MEM_WR stall until mem_rdy; 0 = mem_rdy treated as always 1.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 mem_rdy  in  1  memory access completes this cycle.
REQ-005 op  in  6  opcode from instruction register, bits 31:26.
REQ-006 funct  in  6  function field, bits 5:0; carried only, not decoded here.
REQ-007 PCWr, PCWrCond, IorD, MemRd, MemWr, IRWr, MemtoReg, RegDst, RegWr, ALUSrcA, ExtOp  out  1 each  datapath strobes/selects.
REQ-008 ALUSrcB  out  2  00 regB, 01 const 4, 10 ext imm, 11 ext imm<<2.
REQ-009 PCSrc  out  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-010 ALUOp  out  2  00 add, 01 sub, 10 funct-decoded, 11 op-decoded.
REQ-011 state_o  out  4  current state code; retire  out  1  instruction-complete pulse; ill_op  out  1  sticky illegal opcode.

Function
REQ-012 Moore FSM; all outputs except IRWr/PCWr in FETCH decode from state alone; any strobe not listed for a state is 0; selects not listed are 00/0.
REQ-013 FETCH: MemRd=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00; IRWr=PCWr=mem_rdy; stay while !mem_rdy, else DECODE.
REQ-014 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00, ExtOp=1; next: op 100011/101011->MEM_ADR, 000000->EXEC_R, 000100->BRANCH, 000010->JUMP, 001000/001101->IMM_EX, else FETCH.
REQ-015 MEM_ADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00, ExtOp=1; next MEM_RD if op=100011, else MEM_WR.
REQ-016 MEM_RD: MemRd=1, IorD=1; hold until mem_rdy, then MEM_WB.
REQ-017 MEM_WB: RegWr=1, MemtoReg=1, RegDst=0; next FETCH.
REQ-018 MEM_WR: MemWr=1, IorD=1; hold until mem_rdy, then FETCH.
REQ-019 EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10; next R_WB. R_WB: RegWr=1, RegDst=1, MemtoReg=0; next FETCH.
REQ-020 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWrCond=1, PCSrc=01; next FETCH.
REQ-021 JUMP: PCWr=1, PCSrc=10; next FETCH.
REQ-022 IMM_EX: ALUSrcA=1, ALUSrcB=10, ALUOp=11, ExtOp=1 for addi, 0 for ori; next IMM_WB. IMM_WB: RegWr=1, RegDst=0, MemtoReg=0; next FETCH.
REQ-023 Latency in states with mem_rdy=1 throughout: lw 5, sw 4, R-type 4, addi/ori 4, beq 3, j 3, illegal 2.
REQ-024 retire=1 for exactly one cycle in MEM_WB, MEM_WR with mem_rdy, R_WB, IMM_WB, BRANCH, JUMP; never for illegal op.
REQ-025 ill_op set on DECODE with unsupported op; holds until rst; FSM continues with next FETCH.
REQ-026 MemRd and MemWr never both 1; RegWr and MemWr never both 1.
REQ-027 op/funct sampled only in DECODE, MEM_ADR, IMM_EX; changes elsewhere have no effect.

Reset
REQ-028 rst=1 at a clock edge: state<=FETCH, ill_op<=0, regardless of current state, including mid memory wait.
REQ-029 While rst=1, all outputs forced 0 (state_o reads FETCH code 0); first cycle after release is FETCH.

Structure
REQ-030 Package mc_pkg holds state codes (FETCH=0 ... IMM_WB=11), opcode constants, ALUOp/ALUSrcB/PCSrc codes.
REQ-031 One sub-module mc_out_dec: combinational state(+mem_rdy,op)->control outputs; next-state logic and registers stay in mc_ctrl.

Verification
REQ-032 Reset, op=100011, mem_rdy low 2 cycles in FETCH and 1 in MEM_RD -> IRWr single pulse on 3rd cycle, MEM_WB after 8 cycles total, RegWr=MemtoReg=1, retire once.
REQ-033 op=000000 mem_rdy=1 -> FETCH,DECODE,EXEC_R(ALUOp=10),R_WB(RegWr=1,RegDst=1), retire on 4th cycle.
REQ-034 op=000100 then op=000010 -> BRANCH PCWrCond=1,PCSrc=01; JUMP PCWr=1,PCSrc=10; two retire pulses, 6 cycles total.
REQ-035 op=111111 -> DECODE->FETCH, ill_op=1 and stays through following addi, no retire for illegal op.
REQ-036 op=101011, rst asserted in MEM_WR with mem_rdy=0 -> next cycle all outputs 0, ill_op=0, MemWr never pulsed with mem_rdy; after release FETCH.
REQ-037 op=001101 -> IMM_EX ExtOp=0, ALUOp=11; op=001000 -> ExtOp=1; both IMM_WB RegWr=1,RegDst=0.
